instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/seq_pkg.sv | 68 ++++++
 rtl/op_class_decode.sv | 28 ++
 rtl/instruction_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// opcode map, instruction classes and the bundle of datapath control lines.
package seq_pkg;

    // Control step register. RESET and HALT are the only non-running states.
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [2:0] {
        CLS_LD      = 3'd0,
        CLS_LDI     = 3'd1,
        CLS_ST      = 3'd2,
        CLS_ALU     = 3'd3,
        CLS_BR      = 3'd4,
        CLS_NOP     = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_t;

    // Opcode map (IR[31:27]).
    localparam logic [4:0] OP_LD        = 5'b00000;
    localparam logic [4:0] OP_LDI       = 5'b00001;
    localparam logic [4:0] OP_ST        = 5'b00010;
    localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01100;
    localparam logic [4:0] OP_BR        = 5'b10010;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    // ALU code used for address and branch-target arithmetic.
    localparam logic [4:0] ALU_ADD      = 5'b00011;

    // One bit per datapath control line, so a step can start from '0.
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic mdr_out;
        logic c_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic inc_pc;
        logic read;
        logic write;
        logic con_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
    } ctrl_t;

endpackage

// File: rtl/op_class_decode.sv
// Maps the 5-bit opcode onto the instruction class that selects the
// execute-step sequence. Anything outside the known map is ILLEGAL.
module op_class_decode
    import seq_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    // Pure lookup; the ALU class is a contiguous opcode range.
    always_comb begin
        op_class = CLS_ILLEGAL;
        if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            op_class = CLS_ALU;
        end else begin
            case (opcode)
                OP_LD:   op_class = CLS_LD;
                OP_LDI:  op_class = CLS_LDI;
                OP_ST:   op_class = CLS_ST;
                OP_BR:   op_class = CLS_BR;
                OP_NOP:  op_class = CLS_NOP;
                OP_HALT: op_class = CLS_HALT;
                default: op_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Hardwired control unit: steps T0..T7 per instruction and decodes datapath
// control lines from the current step and the instruction class.
// stop is only honoured when a new fetch would begin, so an instruction in
// progress always finishes before the sequencer parks in HALT.
module instruction_sequencer
    import seq_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       stop,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output logic       PCout,
    output logic       Zlowout,
    output logic       MDRout,
    output logic       Cout,
    output logic       MARin,
    output logic       PCin,
    output logic       MDRin,
    output logic       IRin,
    output logic       Yin,
    output logic       Zin,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic       CONin,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic [4:0] alu_op,
    output logic       run
);

    state_t    state;
    state_t    state_next;
    op_class_t op_class;
    ctrl_t     ctrl;
    logic      to_t0;

    op_class_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // State register; clear drops straight to RESET from any step.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next step; every path that would start a fetch goes through the stop check.
    always_comb begin
        state_next = state;
        to_t0      = 1'b0;
        case (state)
            S_RESET: to_t0 = 1'b1;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2: begin
                case (op_class)
                    CLS_HALT:             state_next = S_HALT;
                    CLS_NOP, CLS_ILLEGAL: to_t0 = 1'b1;
                    default:              state_next = S_T3;
                endcase
            end
            S_T3:    state_next = S_T4;
            S_T4:    state_next = S_T5;
            S_T5: begin
                if (op_class == CLS_LD || op_class == CLS_ST || op_class == CLS_BR) begin
                    state_next = S_T6;
                end else begin
                    to_t0 = 1'b1;
                end
            end
            S_T6: begin
                if (op_class == CLS_LD || op_class == CLS_ST) begin
                    state_next = S_T7;
                end else begin
                    to_t0 = 1'b1;
                end
            end
            S_T7:    to_t0 = 1'b1;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
        if (to_t0) begin
            state_next = stop ? S_HALT : S_T0;
        end
    end

    // Control decode from step and class; anything not named stays 0.
    always_comb begin
        ctrl   = '0;
        alu_op = 5'd0;
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                        ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                        alu_op   = opcode;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
                        alu_op     = ALU_ADD;
                    end
                    CLS_BR: begin
                        ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_ALU, CLS_LDI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
                        alu_op     = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CLS_LD: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.pc_in    = con_ff;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CLS_LD: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_ST:  ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // run marks the active fetch/execute steps.
    always_comb begin
        run = (state != S_RESET) && (state != S_HALT);
    end

    assign PCout   = ctrl.pc_out;
    assign Zlowout = ctrl.zlow_out;
    assign MDRout  = ctrl.mdr_out;
    assign Cout    = ctrl.c_out;
    assign MARin   = ctrl.mar_in;
    assign PCin    = ctrl.pc_in;
    assign MDRin   = ctrl.mdr_in;
    assign IRin    = ctrl.ir_in;
    assign Yin     = ctrl.y_in;
    assign Zin     = ctrl.z_in;
    assign IncPC   = ctrl.inc_pc;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign CONin   = ctrl.con_in;
    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign Rin     = ctrl.r_in;
    assign Rout    = ctrl.r_out;
    assign BAout   = ctrl.ba_out;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: per-cycle vector table of
// {opcode, con_ff, stop, expected step, expected controls, expected alu_op},
// plus hand-timed sequences for clear mid-instruction and reset release.
module tb_instruction_sequencer;
    import seq_pkg::*;

    logic       clock = 1'b0;
    logic       clear;
    logic       stop;
    logic [4:0] opcode;
    logic       con_ff;
    logic       PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin;
    logic       IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_op;
    logic       run;

    instruction_sequencer dut (
        .clock(clock), .clear(clear), .stop(stop), .opcode(opcode), .con_ff(con_ff),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .IncPC(IncPC), .Read(Read), .Write(Write), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // Control bit positions in the compared vector.
    localparam logic [20:0] C_PCOUT = 21'b1 << 20;
    localparam logic [20:0] C_ZLOW  = 21'b1 << 19;
    localparam logic [20:0] C_MDROU = 21'b1 << 18;
    localparam logic [20:0] C_COUT  = 21'b1 << 17;
    localparam logic [20:0] C_MARIN = 21'b1 << 16;
    localparam logic [20:0] C_PCIN  = 21'b1 << 15;
    localparam logic [20:0] C_MDRIN = 21'b1 << 14;
    localparam logic [20:0] C_IRIN  = 21'b1 << 13;
    localparam logic [20:0] C_YIN   = 21'b1 << 12;
    localparam logic [20:0] C_ZIN   = 21'b1 << 11;
    localparam logic [20:0] C_INCPC = 21'b1 << 10;
    localparam logic [20:0] C_READ  = 21'b1 << 9;
    localparam logic [20:0] C_WRITE = 21'b1 << 8;
    localparam logic [20:0] C_CONIN = 21'b1 << 7;
    localparam logic [20:0] C_GRA   = 21'b1 << 6;
    localparam logic [20:0] C_GRB   = 21'b1 << 5;
    localparam logic [20:0] C_GRC   = 21'b1 << 4;
    localparam logic [20:0] C_RIN   = 21'b1 << 3;
    localparam logic [20:0] C_ROUT  = 21'b1 << 2;
    localparam logic [20:0] C_BAOUT = 21'b1 << 1;
    localparam logic [20:0] C_RUN   = 21'b1;

    typedef struct {
        logic [4:0]  op;
        logic        con;
        logic        stp;
        state_t      st;
        logic [20:0] ctrl;
        logic [4:0]  alu;
    } row_t;

    row_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [20:0] ctrl_now();
        return {PCout, Zlowout, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, Zin,
                IncPC, Read, Write, CONin, Gra, Grb, Grc, Rin, Rout, BAout, run};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic check_expect(input string name, input state_t st,
                                input logic [20:0] ctrl, input logic [4:0] alu);
        check_val({name, " state"}, 32'(dut.state), 32'(st));
        check_val({name, " ctrl"},  32'(ctrl_now()), 32'(ctrl));
        check_val({name, " alu_op"}, 32'(alu_op), 32'(alu));
    endtask

    // ---------------- drivers ----------------
    // Rows name controls without run; run follows the expected step.
    task automatic push(input logic [4:0] op, input logic con, input logic stp,
                        input state_t st, input logic [20:0] ctrl, input logic [4:0] alu);
        row_t r;
        r.op = op; r.con = con; r.stp = stp; r.st = st; r.alu = alu;
        r.ctrl = ctrl | ((st != S_RESET && st != S_HALT) ? C_RUN : 21'b0);
        tbl.push_back(r);
    endtask

    task automatic fetch(input logic [4:0] op, input logic con, input logic stp);
        push(op, con, stp, S_T0, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 5'd0);
        push(op, con, stp, S_T1, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 5'd0);
        push(op, con, stp, S_T2, C_MDROU | C_IRIN, 5'd0);
    endtask

    task automatic add_alu(input logic [4:0] op, input logic stp);
        fetch(op, 1'b0, stp);
        push(op, 1'b0, stp, S_T3, C_GRB | C_ROUT | C_YIN, 5'd0);
        push(op, 1'b0, stp, S_T4, C_GRC | C_ROUT | C_ZIN, op);
        push(op, 1'b0, stp, S_T5, C_ZLOW | C_GRA | C_RIN, 5'd0);
    endtask

    task automatic add_addr(input logic [4:0] op);
        fetch(op, 1'b0, 1'b0);
        push(op, 1'b0, 1'b0, S_T3, C_GRB | C_ROUT | C_BAOUT | C_YIN, 5'd0);
        push(op, 1'b0, 1'b0, S_T4, C_COUT | C_ZIN, 5'b00011);
    endtask

    task automatic add_ld();
        add_addr(OP_LD);
        push(OP_LD, 1'b0, 1'b0, S_T5, C_ZLOW | C_MARIN, 5'd0);
        push(OP_LD, 1'b0, 1'b0, S_T6, C_READ | C_MDRIN, 5'd0);
        push(OP_LD, 1'b0, 1'b0, S_T7, C_MDROU | C_GRA | C_RIN, 5'd0);
    endtask

    task automatic add_br(input logic con);
        fetch(OP_BR, con, 1'b0);
        push(OP_BR, con, 1'b0, S_T3, C_GRA | C_ROUT | C_CONIN, 5'd0);
        push(OP_BR, con, 1'b0, S_T4, C_PCOUT | C_YIN, 5'd0);
        push(OP_BR, con, 1'b0, S_T5, C_COUT | C_ZIN, 5'b00011);
        push(OP_BR, con, 1'b0, S_T6, C_ZLOW | (con ? C_PCIN : 21'b0), 5'd0);
    endtask

    // Entered at posedge+1; applies each row for one cycle, checks at negedge.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op;
            con_ff = tbl[i].con;
            stop   = tbl[i].stp;
            @(negedge clock);
            check_expect($sformatf("%s[%0d]", tag, i), tbl[i].st, tbl[i].ctrl, tbl[i].alu);
            @(posedge clock);
            #1;
        end
        tbl.delete();
    endtask

    // Leaves clear released just after a posedge, so the next cycle is RESET.
    task automatic do_reset(input logic stp);
        clear = 1'b1; stop = stp; opcode = 5'd0; con_ff = 1'b0;
        #2;
        check_expect("reset_hold", S_RESET, 21'b0, 5'd0);
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        clear = 1'b1; stop = 1'b0; opcode = 5'd0; con_ff = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Main straight-line program after a clean reset.
        do_reset(1'b0);
        push(5'd0, 1'b0, 1'b0, S_RESET, 21'b0, 5'd0);
        add_alu(5'b00011, 1'b0);                      // add R3,R1,R2
        add_alu(5'b01100, 1'b0);                      // top of ALU range
        add_ld();
        add_addr(OP_LDI);
        push(OP_LDI, 1'b0, 1'b0, S_T5, C_ZLOW | C_GRA | C_RIN, 5'd0);
        add_addr(OP_ST);
        push(OP_ST, 1'b0, 1'b0, S_T5, C_ZLOW | C_MARIN, 5'd0);
        push(OP_ST, 1'b0, 1'b0, S_T6, C_GRA | C_ROUT | C_MDRIN, 5'd0);
        push(OP_ST, 1'b0, 1'b0, S_T7, C_WRITE, 5'd0);
        add_br(1'b0);
        add_br(1'b1);
        fetch(OP_NOP, 1'b0, 1'b0);
        fetch(5'b11111, 1'b0, 1'b0);                  // illegal
        fetch(5'b01101, 1'b0, 1'b0);                  // just past ALU range
        fetch(5'b10011, 1'b0, 1'b0);                  // illegal
        // stop held through an ALU op: it completes, then parks in HALT
        add_alu(5'b00101, 1'b1);
        for (int i = 0; i < 3; i++) push(5'b00011, 1'b1, 1'b0, S_HALT, 21'b0, 5'd0);
        run_table("main");

        // clear pulsed in LD T6: outputs drop at once, one RESET cycle, refetch.
        do_reset(1'b0);
        push(5'd0, 1'b0, 1'b0, S_RESET, 21'b0, 5'd0);
        add_addr(OP_LD);
        push(OP_LD, 1'b0, 1'b0, S_T5, C_ZLOW | C_MARIN, 5'd0);
        run_table("ld_pre");
        opcode = OP_LD;
        @(negedge clock);
        check_expect("ld_t6", S_T6, C_READ | C_MDRIN | C_RUN, 5'd0);
        #2;
        clear = 1'b1;
        #1;
        check_expect("clear_async", S_RESET, 21'b0, 5'd0);
        @(posedge clock);
        #1;
        check_expect("clear_held", S_RESET, 21'b0, 5'd0);
        clear = 1'b0;
        push(OP_LD, 1'b0, 1'b0, S_RESET, 21'b0, 5'd0);
        add_ld();
        run_table("ld_post");

        // stop present when RESET ends: straight to HALT, no fetch.
        do_reset(1'b1);
        push(5'd0, 1'b0, 1'b1, S_RESET, 21'b0, 5'd0);
        for (int i = 0; i < 3; i++) push(5'd0, 1'b0, 1'b0, S_HALT, 21'b0, 5'd0);
        run_table("stop_rst");

        // HALT opcode: absorbing for 20 cycles whatever the inputs do.
        do_reset(1'b0);
        push(5'd0, 1'b0, 1'b0, S_RESET, 21'b0, 5'd0);
        fetch(OP_HALT, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            push(5'(i), 1'(i), 1'b0, S_HALT, 21'b0, 5'd0);
        run_table("halt_op");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
